// File: rtl/lcd_sync_rx.sv
// lcd_sync_rx: LCD parallel video receiver; raw NCLK/HD/VD/DEN/RGB in, per-pixel Columna/Fila/PIX_* out, frame size, lock and error status.
module lcd_sync_rx #(
  parameter int EXP_H_ACTIVE = 800,
  parameter int EXP_V_ACTIVE = 480,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        NCLK,
  input  logic        HD,
  input  logic        VD,
  input  logic        DEN,
  input  logic [7:0]  R,
  input  logic [7:0]  G,
  input  logic [7:0]  B,
  output logic        PIX_VALID,
  output logic [10:0] Columna,
  output logic [9:0]  Fila,
  output logic [7:0]  PIX_R,
  output logic [7:0]  PIX_G,
  output logic [7:0]  PIX_B,
  output logic        FRAME_START,
  output logic        LOCKED,
  output logic        ERR,
  output logic [10:0] H_ACTIVE,
  output logic [9:0]  V_ACTIVE
);
  typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;
  state_t state_q, state_d;
  logic nclk_s1_q, nclk_s2_q, hd_s1_q, vd_s1_q, den_s1_q, prev_hd_q, prev_vd_q;
  logic [23:0] rgb_s1_q, rgb_o_q, rgb_o_d;
  logic [10:0] col_q, col_d, ref_q, ref_d, col_o_q, col_o_d, h_q, h_d;
  logic [9:0] row_q, row_d, row_o_q, row_o_d, v_q, v_d;
  logic [3:0] cnt_q, cnt_d;
  logic had_q, had_d, bad_q, bad_d, pix_q, pix_d, fs_q, fs_d, err_q, err_d;
  logic strobe, hd_fall, vd_fall, good, active;
  always_comb begin
    strobe = nclk_s1_q & ~nclk_s2_q;
    hd_fall = strobe & prev_hd_q & ~hd_s1_q;
    vd_fall = strobe & prev_vd_q & ~vd_s1_q;
    active = state_q != ST_SEARCH;
    state_d = state_q;
    cnt_d = cnt_q;
    col_d = col_q;
    row_d = row_q;
    ref_d = ref_q;
    had_d = had_q;
    bad_d = bad_q;
    h_d = h_q;
    v_d = v_q;
    col_o_d = col_o_q;
    row_o_d = row_o_q;
    rgb_o_d = rgb_o_q;
    pix_d = 1'b0;
    fs_d = 1'b0;
    err_d = 1'b0;
    // A VD fall without its own HD fall still closes the open line, so one close covers both cases
    if ((hd_fall | vd_fall) & had_q) begin
      ref_d = (ref_q == 11'd0) ? col_q : ref_q;
      bad_d = bad_q | ((ref_q != 11'd0) & (col_q != ref_q));
      row_d = (row_q == 10'h3ff) ? row_q : row_q + 10'd1;
    end
    if (hd_fall | vd_fall) begin
      col_d = '0;
      had_d = 1'b0;
    end
    good = ~bad_d & (ref_d == 11'(EXP_H_ACTIVE)) & (row_d == 10'(EXP_V_ACTIVE));
    if (vd_fall) begin
      fs_d = 1'b1;
      h_d = active ? ref_d : h_q;
      v_d = active ? row_d : v_q;
      case (state_q)
        ST_SEARCH: begin
          state_d = ST_MEASURE;
          cnt_d = '0;
        end
        ST_MEASURE: begin
          cnt_d = good ? cnt_q + 4'd1 : 4'd0;
          state_d = (good && (cnt_q + 4'd1 == 4'(LOCK_FRAMES))) ? ST_LOCKED : ST_MEASURE;
        end
        default: if (!good) begin
          state_d = ST_MEASURE;
          cnt_d = '0;
          err_d = 1'b1;
        end
      endcase
      row_d = '0;
      ref_d = '0;
      bad_d = 1'b0;
    end
    if (strobe & den_s1_q) begin
      had_d = 1'b1;
      if (col_d == 11'h7ff) begin
        bad_d = 1'b1;
        err_d = err_d | active;
      end else begin
        pix_d = active;
        col_o_d = active ? col_d : col_o_q;
        row_o_d = active ? row_d : row_o_q;
        rgb_o_d = active ? rgb_s1_q : rgb_o_q;
        col_d = col_d + 11'd1;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      nclk_s1_q <= 1'b0;
      nclk_s2_q <= 1'b0;
      hd_s1_q <= 1'b0;
      vd_s1_q <= 1'b0;
      den_s1_q <= 1'b0;
      rgb_s1_q <= '0;
      prev_hd_q <= 1'b1;
      prev_vd_q <= 1'b1;
      state_q <= ST_SEARCH;
      cnt_q <= '0;
      col_q <= '0;
      row_q <= '0;
      ref_q <= '0;
      had_q <= 1'b0;
      bad_q <= 1'b0;
      h_q <= '0;
      v_q <= '0;
      col_o_q <= '0;
      row_o_q <= '0;
      rgb_o_q <= '0;
      pix_q <= 1'b0;
      fs_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      nclk_s1_q <= NCLK;
      nclk_s2_q <= nclk_s1_q;
      hd_s1_q <= HD;
      vd_s1_q <= VD;
      den_s1_q <= DEN;
      rgb_s1_q <= {R, G, B};
      prev_hd_q <= strobe ? hd_s1_q : prev_hd_q;
      prev_vd_q <= strobe ? vd_s1_q : prev_vd_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      col_q <= col_d;
      row_q <= row_d;
      ref_q <= ref_d;
      had_q <= had_d;
      bad_q <= bad_d;
      h_q <= h_d;
      v_q <= v_d;
      col_o_q <= col_o_d;
      row_o_q <= row_o_d;
      rgb_o_q <= rgb_o_d;
      pix_q <= pix_d;
      fs_q <= fs_d;
      err_q <= err_d;
    end
  end
  assign PIX_VALID = pix_q;
  assign Columna = col_o_q;
  assign Fila = row_o_q;
  assign {PIX_R, PIX_G, PIX_B} = rgb_o_q;
  assign FRAME_START = fs_q;
  assign LOCKED = state_q == ST_LOCKED;
  assign ERR = err_q;
  assign H_ACTIVE = h_q;
  assign V_ACTIVE = v_q;
endmodule
